regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-write/dual-read integer register file. Generalised in data width, register count and read-port count.
- Adds a synchronous clocked write, asynchronous reset of all registers, and per-register busy (scoreboard) bits for multi-cycle producers (load, mul/div).
- Sits between decode (reads, busy checks, busy set at issue) and writeback (write, busy clear) of the RV64IM pipeline.

Parameters:
- XLEN, 64, data width of each register.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- NUM_READ, 2, number of independent read ports (1..4).
- AW, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- R_ADDR  in  NUM_READ*AW  read addresses, port i at bits [i*AW +: AW].
- R_DATA  out  NUM_READ*XLEN  read data, port i at bits [i*XLEN +: XLEN].
- R_BUSY  out  NUM_READ  busy bit of the register addressed by port i.
- RD  in  AW  write address.
- RD_DATA  in  XLEN  write data.
- WE  in  1  write enable.
- BUSY_SET  in  1  mark register BUSY_ADDR pending (issue of a multi-cycle op).
- BUSY_ADDR  in  AW  register to mark busy.
- FLUSH  in  1  clear all busy bits (pipeline flush).

Behaviour:
- Reset: asynchronous, while RESET=1.
  - All registers go to 0 and all busy bits go to 0.
  - R_DATA therefore reads 0 and R_BUSY reads 0 for every port.
  - A write, BUSY_SET or FLUSH in the same cycle as RESET is ignored.
- Reads: combinational, zero latency.
  - R_DATA[i] = reg[R_ADDR[i]].
  - Address 0 always returns 0 and busy 0.
  - Address >= NUM_REGS (non-power-of-2 NUM_REGS) returns 0 and busy 0.
- Write: on rising CLK with WE=1 and RD!=0, reg[RD] <= RD_DATA.
  - Visible on R_DATA the cycle after the edge (unless bypass is enabled, see Optional Feature).
  - WE with RD=0, or with an out-of-range RD, is a no-op.
- Busy bits: one per register; bit 0 is constant 0.
  - Set on a CLK edge with BUSY_SET=1 and BUSY_ADDR!=0.
  - Cleared on a CLK edge by a write (WE=1) to that register.
  - Set and write to the same register in the same cycle: set wins, because a new producer was issued while the old one retires.
  - Set and write to different registers: both take effect.
  - FLUSH=1 clears all busy bits. FLUSH and BUSY_SET in the same cycle: FLUSH clears everything, then the set applies, so only BUSY_ADDR ends busy.
  - Setting an already-busy bit keeps it busy; there is no counting.
- All read ports are independent; any number of ports may address the same register.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When WE=1, RD!=0 and R_ADDR[i]==RD, R_DATA[i]=RD_DATA combinationally in the same cycle, and R_BUSY[i]=0 unless BUSY_SET targets the same register that cycle. Decode sees writeback data without a stall.
- Undefined: reads return stored contents only; the pipeline inserts one stall for write-then-read in the same cycle.

Decomposition:
- Shared package regfile_pkg:
  - constants XLEN_DEF=64, NUM_REGS_DEF=32, ZERO_REG=0;
  - typedef for register address (logic [AW-1:0]);
  - typedef for data word (logic [XLEN-1:0]).
- One natural sub-module: regfile_scoreboard, holding the busy-bit vector with set, clear, flush and reset logic, instantiated once.
- Data storage and read muxes stay in regfile_mp.

Test Plan:
- Reset then read: RESET=1 for 2 cycles, release; R_ADDR ports = 0,5 -> R_DATA = 0,0 and R_BUSY = 0,0.
- Write and read back: WE=1, RD=1, RD_DATA=5, then WE=1, RD=2, RD_DATA=10; next cycle ports read 1,2 -> 5,10. WE=1, RD=0, RD_DATA=0xFFFF -> port reading 0 still returns 0.
- Bypass:
  - Bypass defined: WE=1, RD=3, RD_DATA=0xABCD with R_ADDR[0]=3 in the same cycle -> R_DATA[0]=0xABCD before the edge.
  - Bypass undefined: stale value 0 before the edge, 0xABCD after.
- Scoreboard:
  - BUSY_SET on reg 7 -> R_BUSY=1 next cycle.
  - Write reg 7 with 0x42 -> busy 0 next cycle and data 0x42.
  - Same-cycle BUSY_SET(7) plus WE(7) -> busy stays 1 and data is updated.
- Flush: set busy on regs 4 and 9; FLUSH=1 with BUSY_SET(9) -> reg 4 not busy, reg 9 busy.
- Reset mid-operation: registers 1..3 written and reg 5 busy; pulse RESET asynchronously between edges -> all R_DATA=0 and R_BUSY=0 immediately, with no wait for CLK.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//
// Contents:
//   XLEN_DEF, NUM_REGS_DEF : default data width and register count
//   ZERO_REG               : index of the hardwired-zero register
//   AW_DEF                 : address width for the default register count
//   reg_addr_t, data_t     : register address and data word types for the
//                            default configuration
package regfile_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_REG     = 0;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending bit per register 1..NUM_REGS-1.
// Register 0 has no busy bit and always reads not-busy.
//
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   we_i, wr_addr_i  : writeback; clears the busy bit of wr_addr_i
//   set_i, set_addr_i: issue of a multi-cycle op; sets busy of set_addr_i
//   flush_i          : clears every busy bit
//   busy_o           : busy vector, bit r for register r
//
// Priority within one edge: write-clear and flush first, then set, so a new
// producer issued in the same cycle always ends busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic                  set_i,
  input  logic [AW-1:0]         set_addr_i,
  input  logic                  flush_i,
  output logic [NUM_REGS-1:1]   busy_o
);

  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:1] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end
      if (we_i && (wr_addr_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
      // Set is evaluated last so it overrides both clear sources.
      if (set_i && (set_addr_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with busy scoreboard.
//
// Optional feature (macro REGFILE_BYPASS_EN): write-through forwarding of the
// writeback data to any read port addressing the register being written.
//
// Ports:
//   CLK, RESET : clock, asynchronous active-high reset
//   R_ADDR     : NUM_READ read addresses, port i at [i*AW +: AW]
//   R_DATA     : NUM_READ read data words, port i at [i*XLEN +: XLEN]
//   R_BUSY     : busy bit of the register addressed by each port
//   RD, RD_DATA, WE : write address, data, enable
//   BUSY_SET, BUSY_ADDR : mark a register pending
//   FLUSH      : clear all busy bits
//
// Register 0 and out-of-range addresses read as zero / not busy; writes to
// them are dropped.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_READ = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_READ*AW-1:0]   R_ADDR,
  output logic [NUM_READ*XLEN-1:0] R_DATA,
  output logic [NUM_READ-1:0]      R_BUSY,
  input  logic [AW-1:0]            RD,
  input  logic [XLEN-1:0]          RD_DATA,
  input  logic                     WE,
  input  logic                     BUSY_SET,
  input  logic [AW-1:0]            BUSY_ADDR,
  input  logic                     FLUSH
);

  // Storage only for registers 1..NUM_REGS-1; register 0 is implicit zero.
  logic [XLEN-1:0]     regs_q [NUM_REGS-1:1];
  logic [XLEN-1:0]     regs_d [NUM_REGS-1:1];
  logic [NUM_REGS-1:1] busy;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .we_i       (WE),
    .wr_addr_i  (RD),
    .set_i      (BUSY_SET),
    .set_addr_i (BUSY_ADDR),
    .flush_i    (FLUSH),
    .busy_o     (busy)
  );

  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (WE && (RD == AW'(r)) && (RD != AW'(ZERO_REG))) begin
        regs_d[r] = RD_DATA;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Read muxes: matching only indices 1..NUM_REGS-1 makes address 0 and any
  // out-of-range address fall through to the zero default.
  always_comb begin
    R_DATA = '0;
    R_BUSY = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (R_ADDR[p*AW +: AW] == AW'(r)) begin
          R_DATA[p*XLEN +: XLEN] = regs_q[r];
          R_BUSY[p]              = busy[r];
`ifdef REGFILE_BYPASS_EN
          // Forward writeback data; the register is no longer pending unless
          // a new producer targets it in this same cycle. Suppressed during
          // reset so every port reads zero while RESET is high.
          if (!RESET && WE && (RD == AW'(r))) begin
            R_DATA[p*XLEN +: XLEN] = RD_DATA;
            R_BUSY[p]              = BUSY_SET && (BUSY_ADDR == AW'(r));
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREG  = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                 clk;
  logic                 rst;
  logic [NRD*AW-1:0]    r_addr;
  logic [NRD*XLEN-1:0]  r_data;
  logic [NRD-1:0]       r_busy;
  logic [AW-1:0]        rd;
  logic [XLEN-1:0]      rd_data;
  logic                 we;
  logic                 busy_set;
  logic [AW-1:0]        busy_addr;
  logic                 flush;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: architectural register values and pending flags.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  regfile_mp #(
    .XLEN     (XLEN),
    .NUM_REGS (NREG),
    .NUM_READ (NRD)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .R_ADDR    (r_addr),
    .R_DATA    (r_data),
    .R_BUSY    (r_busy),
    .RD        (rd),
    .RD_DATA   (rd_data),
    .WE        (we),
    .BUSY_SET  (busy_set),
    .BUSY_ADDR (busy_addr),
    .FLUSH     (flush)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(int a);
    if (rst || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && int'(rd) == a) return rd_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(int a);
    if (rst || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && int'(rd) == a) return busy_set && int'(busy_addr) == a;
`endif
    return m_busy[a];
  endfunction

  // One rising edge; the model applies the architectural rules to the inputs
  // that were present before the edge.
  task automatic tick();
    logic [XLEN-1:0] n_regs [NREG];
    bit              n_busy [NREG];
    for (int r = 0; r < NREG; r++) begin
      n_regs[r] = m_regs[r];
      n_busy[r] = m_busy[r];
    end
    if (!rst) begin
      if (we && rd != 0) begin
        n_regs[rd] = rd_data;
        n_busy[rd] = 1'b0;
      end
      if (flush) for (int r = 0; r < NREG; r++) n_busy[r] = 1'b0;
      if (busy_set && busy_addr != 0) n_busy[busy_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = n_regs[r];
      m_busy[r] = n_busy[r];
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    we = 1'b0; rd = '0; rd_data = '0;
    busy_set = 1'b0; busy_addr = '0; flush = 1'b0;
  endtask

  task automatic set_addr(int a0, int a1);
    r_addr[0*AW +: AW] = AW'(a0);
    r_addr[1*AW +: AW] = AW'(a1);
  endtask

  task automatic do_write(int a, logic [XLEN-1:0] d);
    we = 1'b1; rd = AW'(a); rd_data = d;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_all(string tag);
    logic [XLEN-1:0] ed;
    logic            eb;
    int              a;
    #1;
    for (int p = 0; p < NRD; p++) begin
      a  = int'(r_addr[p*AW +: AW]);
      ed = exp_data(a);
      eb = exp_busy(a);
      tests_run++;
      assert (r_data[p*XLEN +: XLEN] === ed) else begin
        tests_failed++;
        $error("FAIL %s data p%0d addr %0d got %h exp %h", tag, p, a,
               r_data[p*XLEN +: XLEN], ed);
      end
      tests_run++;
      assert (r_busy[p] === eb) else begin
        tests_failed++;
        $error("FAIL %s busy p%0d addr %0d got %b exp %b", tag, p, a,
               r_busy[p], eb);
      end
    end
  endtask

  // Direct check against a constant the test plan states outright.
  task automatic check_const(string tag, int p, logic [XLEN-1:0] ed, logic eb);
    tests_run++;
    assert (r_data[p*XLEN +: XLEN] === ed) else begin
      tests_failed++;
      $error("FAIL %s data p%0d got %h exp %h", tag, p, r_data[p*XLEN +: XLEN], ed);
    end
    tests_run++;
    assert (r_busy[p] === eb) else begin
      tests_failed++;
      $error("FAIL %s busy p%0d got %b exp %b", tag, p, r_busy[p], eb);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    set_addr(0, 5);
    model_clear();
    rst = 1'b1;
    tick();
    tick();
    check_all("in_reset");
    rst = 1'b0;
    set_addr(0, 5);
    check_all("after_reset");
    check_const("after_reset_c", 1, 64'h0, 1'b0);

    // Write and read back.
    do_write(1, 64'd5);
    tick();
    do_write(2, 64'd10);
    tick();
    idle();
    set_addr(1, 2);
    check_all("readback");
    check_const("readback_r1", 0, 64'd5, 1'b0);
    check_const("readback_r2", 1, 64'd10, 1'b0);

    // Write to register 0 is dropped.
    do_write(0, 64'hFFFF);
    set_addr(0, 1);
    check_all("wr0_pre");
    tick();
    idle();
    check_all("wr0_post");
    check_const("wr0_c", 0, 64'h0, 1'b0);

    // Same-cycle write and read of register 3.
    do_write(3, 64'hABCD);
    set_addr(3, 1);
    check_all("bypass_pre");
`ifdef REGFILE_BYPASS_EN
    check_const("bypass_fwd", 0, 64'hABCD, 1'b0);
`else
    check_const("bypass_stale", 0, 64'h0, 1'b0);
`endif
    tick();
    idle();
    check_all("bypass_post");
    check_const("bypass_post_c", 0, 64'hABCD, 1'b0);

    // Scoreboard: set, clear by write, set wins over write.
    busy_set = 1'b1; busy_addr = 5'd7;
    tick();
    idle();
    set_addr(7, 0);
    check_all("busy_set");
    check_const("busy_set_c", 0, 64'h0, 1'b1);
    do_write(7, 64'h42);
    tick();
    idle();
    check_all("busy_clr");
    check_const("busy_clr_c", 0, 64'h42, 1'b0);
    busy_set = 1'b1; busy_addr = 5'd7;
    do_write(7, 64'h99);
    tick();
    idle();
    check_all("set_wins");
    check_const("set_wins_c", 0, 64'h99, 1'b1);

    // Flush with simultaneous set.
    busy_set = 1'b1; busy_addr = 5'd4;
    tick();
    busy_addr = 5'd9;
    tick();
    idle();
    set_addr(4, 9);
    check_all("pre_flush");
    flush = 1'b1; busy_set = 1'b1; busy_addr = 5'd9;
    tick();
    idle();
    check_all("flush_set");
    check_const("flush_r4", 0, 64'h0, 1'b0);
    check_const("flush_r9", 1, 64'h0, 1'b1);

    // Asynchronous reset between edges.
    for (int r = 1; r <= 3; r++) begin
      do_write(r, 64'h100 + 64'(r));
      tick();
    end
    idle();
    busy_set = 1'b1; busy_addr = 5'd5;
    tick();
    idle();
    set_addr(2, 5);
    check_all("pre_async_rst");
    #2;
    rst = 1'b1;
    do_write(1, 64'hDEAD);
    model_clear();
    check_all("async_rst");
    check_const("async_rst_r2", 0, 64'h0, 1'b0);
    check_const("async_rst_r5", 1, 64'h0, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    set_addr(1, 3);
    check_all("post_async_rst");

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      we        = ($urandom_range(0, 99) < 50);
      rd        = AW'($urandom_range(0, NREG - 1));
      rd_data   = {$urandom, $urandom};
      busy_set  = ($urandom_range(0, 99) < 30);
      busy_addr = AW'($urandom_range(0, NREG - 1));
      flush     = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 3) == 0) set_addr(int'(rd), int'(busy_addr));
      else set_addr($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
      check_all("rand_pre");
      tick();
    end
    idle();
    for (int r = 0; r < NREG; r += 2) begin
      set_addr(r, r + 1);
      check_all("final_sweep");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
